// File: rtl/uart_frame_sender_pkg.sv
// Shared definitions for the UART frame sender: frame byte layout, FSM states
// and the helper that assembles a command frame.
package uart_frame_sender_pkg;

    localparam int unsigned OPCDBYTE = 2;
    localparam int unsigned ADDRBYTE = 2;
    localparam int unsigned DATABYTE = 4;
    localparam int unsigned BYTES    = OPCDBYTE + ADDRBYTE + DATABYTE;
    localparam int unsigned DWIDTH   = 8;
    localparam int unsigned FWIDTH   = BYTES * DWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef logic [FWIDTH-1:0] frame_t;

    function automatic frame_t frame_pack(
        input logic [OPCDBYTE*DWIDTH-1:0] op,
        input logic [ADDRBYTE*DWIDTH-1:0] addr,
        input logic [DATABYTE*DWIDTH-1:0] data
    );
        return {op, addr, data};
    endfunction

endpackage

// File: rtl/uart_frame_fifo.sv
// Frame-wide synchronous FIFO; pointers wrap modulo DEPTH (power of two).
module uart_frame_fifo
    import uart_frame_sender_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  frame_t        i_data,
    input  logic          i_pop,
    output frame_t        o_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    frame_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    // A push while full is refused even if a pop happens in the same cycle.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_sender.sv
// Buffers 8-byte command frames and feeds them MSB-byte-first to the UART
// transmitter through its start/busy/done handshake.
module uart_frame_sender
    import uart_frame_sender_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          iCLOCK,
    input  logic          iRESET,
    input  logic          iWRITE,
    input  logic [15:0]   iOPCODE,
    input  logic [15:0]   iADDR,
    input  logic [31:0]   iDATA,
    output logic          oREADY,
    output logic [CW-1:0] oCOUNT,
    output logic          oTXSTART,
    output logic [7:0]    oTXDATA,
    input  logic          iTXBUSY,
    input  logic          iTXDONE,
    output logic          oFRAMEDONE,
    output logic          oBUSY
);

    localparam int unsigned IW = $clog2(BYTES);

    frame_t          w_frame;
    frame_t          w_head;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;

    state_t          r_state;
    frame_t          r_shift;
    logic [IW-1:0]   r_idx;
    logic            r_txstart;
    logic            r_framedone;

    assign w_frame = frame_pack(iOPCODE, iADDR, iDATA);
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;

    uart_frame_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (iCLOCK),
        .i_rst   (iRESET),
        .i_push  (iWRITE),
        .i_data  (w_frame),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_txstart   <= 1'b0;
            r_framedone <= 1'b0;
        end else begin
            r_txstart   <= 1'b0;
            r_framedone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_idx   <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!iTXBUSY) begin
                        r_txstart <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (iTXDONE) begin
                        if (r_idx == IW'(BYTES - 1)) begin
                            r_framedone <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_shift <= {r_shift[FWIDTH-DWIDTH-1:0], {DWIDTH{1'b0}}};
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oREADY     = !w_full;
    assign oCOUNT     = w_count;
    assign oTXSTART   = r_txstart;
    assign oTXDATA    = r_shift[FWIDTH-1 -: DWIDTH];
    assign oFRAMEDONE = r_framedone;
    assign oBUSY      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Scoreboard bench for uart_frame_sender: expected bytes are queued on write,
// a monitor checks each transmit request and frame completion.
module tb_uart_frame_sender;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    logic          iCLOCK  = 1'b0;
    logic          iRESET  = 1'b0;
    logic          iWRITE  = 1'b0;
    logic [15:0]   iOPCODE = '0;
    logic [15:0]   iADDR   = '0;
    logic [31:0]   iDATA   = '0;
    logic          oREADY;
    logic [CW-1:0] oCOUNT;
    logic          oTXSTART;
    logic [7:0]    oTXDATA;
    logic          iTXBUSY;
    logic          iTXDONE;
    logic          oFRAMEDONE;
    logic          oBUSY;

    logic        tx_busy    = 1'b0;
    logic        tx_done    = 1'b0;
    logic        force_busy = 1'b0;
    logic        spur_done  = 1'b0;
    int unsigned tx_delay   = 4;
    int unsigned tx_cnt     = 0;

    assign iTXBUSY = tx_busy | force_busy;
    assign iTXDONE = tx_done | spur_done;

    int          checks = 0;
    int          errors = 0;
    int unsigned starts_total = 0;
    int unsigned frames_done  = 0;
    exp_t        exp_q[$];
    bit          outstanding = 1'b0;
    bit          cur_last    = 1'b0;
    logic [7:0]  cur_byte    = '0;

    uart_frame_sender #(.DEPTH(DEPTH)) dut (
        .iCLOCK     (iCLOCK),
        .iRESET     (iRESET),
        .iWRITE     (iWRITE),
        .iOPCODE    (iOPCODE),
        .iADDR      (iADDR),
        .iDATA      (iDATA),
        .oREADY     (oREADY),
        .oCOUNT     (oCOUNT),
        .oTXSTART   (oTXSTART),
        .oTXDATA    (oTXDATA),
        .iTXBUSY    (iTXBUSY),
        .iTXDONE    (iTXDONE),
        .oFRAMEDONE (oFRAMEDONE),
        .oBUSY      (oBUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] op, input logic [15:0] ad, input logic [31:0] d);
        return {op, ad, d};
    endfunction

    // Caller positions this at a negedge; the write is taken at the next posedge.
    task automatic drive(input logic [63:0] f, input bit accept);
        iWRITE  = 1'b1;
        iOPCODE = f[63:48];
        iADDR   = f[47:32];
        iDATA   = f[31:0];
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back('{b: f[63-8*i -: 8], last: (i == 7)});
            end
        end
    endtask

    task automatic wait_frames(input int unsigned target, input int unsigned budget, input string name);
        int unsigned n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(posedge iCLOCK);
            #2;
            n++;
        end
        chk(name, 64'(frames_done >= target), 64'd1);
    endtask

    // Transmitter model: busy from the cycle after start, done pulse tx_delay cycles later.
    initial begin
        forever begin
            @(negedge iCLOCK);
            if (iRESET) begin
                tx_cnt  = 0;
                tx_busy = 1'b0;
                tx_done = 1'b0;
            end else begin
                tx_done = 1'b0;
                if (tx_cnt != 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        tx_done = 1'b1;
                        tx_busy = 1'b0;
                    end
                end else if (oTXSTART) begin
                    tx_busy = 1'b1;
                    tx_cnt  = tx_delay;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each transmit request.
    initial begin
        exp_t e;
        bit   fd_exp;
        forever begin
            @(posedge iCLOCK);
            #1;
            if (iRESET) begin
                exp_q.delete();
                outstanding = 1'b0;
            end else begin
                fd_exp = iTXDONE && outstanding && cur_last;
                if (fd_exp || oFRAMEDONE) begin
                    chk("framedone", 64'(oFRAMEDONE), 64'(fd_exp));
                end
                if (oFRAMEDONE) begin
                    frames_done++;
                end
                if (iTXDONE) begin
                    outstanding = 1'b0;
                end
                if (oTXSTART) begin
                    chk("start_while_busy", 64'(iTXBUSY), 64'd0);
                    chk("start_without_done", 64'(outstanding), 64'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: actual=%0h required=none", oTXDATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txdata", 64'(oTXDATA), 64'(e.b));
                        cur_byte = e.b;
                        cur_last = e.last;
                    end
                    outstanding = 1'b1;
                    starts_total++;
                end else if (outstanding) begin
                    chk("txdata_hold", 64'(oTXDATA), 64'(cur_byte));
                end
            end
        end
    end

    initial begin
        logic [63:0] f;
        logic [63:0] last_f;
        int unsigned base;
        int unsigned fbase;
        int unsigned acc;
        int unsigned n;

        #2 iRESET = 1'b1;
        repeat (2) @(negedge iCLOCK);
        chk("rst_ready", 64'(oREADY), 64'd1);
        chk("rst_count", 64'(oCOUNT), 64'd0);
        chk("rst_txstart", 64'(oTXSTART), 64'd0);
        chk("rst_txdata", 64'(oTXDATA), 64'h00);
        chk("rst_framedone", 64'(oFRAMEDONE), 64'd0);
        chk("rst_busy", 64'(oBUSY), 64'd0);
        iRESET = 1'b0;

        // Single frame with a slow transmitter, including first-byte latency.
        tx_delay = 100;
        base = starts_total;
        f = mk(16'hA55A, 16'h0102, 32'hDEADBEEF);
        @(negedge iCLOCK) drive(f, 1'b1);
        @(posedge iCLOCK); #1;
        chk("lat_count1", 64'(oCOUNT), 64'd1);
        @(negedge iCLOCK) iWRITE = 1'b0;
        @(posedge iCLOCK); #1;
        chk("lat_count0", 64'(oCOUNT), 64'd0);
        chk("lat_nostart", 64'(oTXSTART), 64'd0);
        chk("lat_load", 64'(oTXDATA), 64'hA5);
        @(posedge iCLOCK); #1;
        chk("lat_start", 64'(oTXSTART), 64'd1);
        wait_frames(1, 2000, "single_done");
        chk("single_starts", 64'(starts_total - base), 64'd8);

        // Start withheld while the transmitter reports busy.
        tx_delay = 6;
        base  = starts_total;
        fbase = frames_done;
        @(negedge iCLOCK);
        force_busy = 1'b1;
        drive(mk(16'h1111, 16'h2222, 32'h33334444), 1'b1);
        @(negedge iCLOCK) iWRITE = 1'b0;
        repeat (50) @(negedge iCLOCK);
        chk("busy_withheld", 64'(starts_total - base), 64'd0);
        force_busy = 1'b0;
        repeat (3) @(posedge iCLOCK);
        #2;
        chk("busy_single", 64'(starts_total - base), 64'd1);
        wait_frames(fbase + 1, 500, "busy_done");

        // Fill with transmitter stalled: five accepted, sixth dropped.
        tx_delay = 4;
        fbase = frames_done;
        @(negedge iCLOCK);
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge iCLOCK);
            f = mk(16'hC000 + 16'(i), 16'hA000 + 16'(i), $urandom);
            drive(f, i < 5);
        end
        @(negedge iCLOCK) iWRITE = 1'b0;
        @(posedge iCLOCK); #1;
        chk("full_count", 64'(oCOUNT), 64'(DEPTH));
        chk("full_ready", 64'(oREADY), 64'd0);
        chk("full_busy", 64'(oBUSY), 64'd1);
        @(negedge iCLOCK) force_busy = 1'b0;
        wait_frames(fbase + 5, 3000, "full_drain");
        repeat (20) @(negedge iCLOCK);
        chk("full_drop", 64'(exp_q.size()), 64'd0);
        chk("full_idle", 64'(oBUSY), 64'd0);

        // Write coinciding with a pop at count 2.
        tx_delay = 3;
        fbase = frames_done;
        @(negedge iCLOCK);
        force_busy = 1'b1;
        drive(mk(16'h0A0A, 16'h0001, 32'h01010101), 1'b1);
        @(negedge iCLOCK) drive(mk(16'h0B0B, 16'h0002, 32'h02020202), 1'b1);
        @(negedge iCLOCK) drive(mk(16'h0C0C, 16'h0003, 32'h03030303), 1'b1);
        @(negedge iCLOCK);
        iWRITE = 1'b0;
        force_busy = 1'b0;
        n = 0;
        while (!oFRAMEDONE && n < 1000) begin
            @(posedge iCLOCK);
            #2;
            n++;
        end
        chk("simul_fd_seen", 64'(oFRAMEDONE), 64'd1);
        chk("simul_count_before", 64'(oCOUNT), 64'd2);
        last_f = mk(16'h0D0D, 16'h0004, 32'h04040404);
        @(negedge iCLOCK) drive(last_f, 1'b1);
        @(posedge iCLOCK); #2;
        chk("simul_count_after", 64'(oCOUNT), 64'd2);
        @(negedge iCLOCK) iWRITE = 1'b0;
        wait_frames(fbase + 4, 1000, "simul_drain");
        repeat (10) @(negedge iCLOCK);
        chk("simul_empty", 64'(exp_q.size()), 64'd0);

        // Spurious done in IDLE and in ISSUE.
        fbase = frames_done;
        @(negedge iCLOCK) spur_done = 1'b1;
        @(negedge iCLOCK) spur_done = 1'b0;
        repeat (2) @(posedge iCLOCK);
        #2;
        chk("spur_idle_data", 64'(oTXDATA), 64'(last_f[7:0]));
        chk("spur_idle_busy", 64'(oBUSY), 64'd0);
        chk("spur_idle_frames", 64'(frames_done - fbase), 64'd0);
        base = starts_total;
        f = mk(16'h5EED, 16'hF00D, 32'h12345678);
        @(negedge iCLOCK);
        force_busy = 1'b1;
        drive(f, 1'b1);
        @(negedge iCLOCK) iWRITE = 1'b0;
        repeat (4) @(negedge iCLOCK);
        spur_done = 1'b1;
        @(negedge iCLOCK) spur_done = 1'b0;
        repeat (3) @(posedge iCLOCK);
        #2;
        chk("spur_issue_data", 64'(oTXDATA), 64'(f[63:56]));
        chk("spur_issue_nostart", 64'(starts_total - base), 64'd0);
        @(negedge iCLOCK) force_busy = 1'b0;
        wait_frames(fbase + 1, 500, "spur_done_frame");

        // Reset in the middle of byte 3 with two frames queued.
        tx_delay = 20;
        base  = starts_total;
        fbase = frames_done;
        @(negedge iCLOCK) drive(mk(16'h1001, 16'h2002, 32'h30034004), 1'b1);
        @(negedge iCLOCK) drive(mk(16'h5005, 16'h6006, 32'h70078008), 1'b1);
        @(negedge iCLOCK) drive(mk(16'h9009, 16'hA00A, 32'hB00BC00C), 1'b1);
        @(negedge iCLOCK) iWRITE = 1'b0;
        n = 0;
        while (starts_total - base < 4 && n < 1000) begin
            @(negedge iCLOCK);
            n++;
        end
        chk("rst_reach_byte3", 64'(starts_total - base), 64'd4);
        repeat (5) @(negedge iCLOCK);
        iRESET = 1'b1;
        #1;
        chk("midrst_ready", 64'(oREADY), 64'd1);
        chk("midrst_count", 64'(oCOUNT), 64'd0);
        chk("midrst_txstart", 64'(oTXSTART), 64'd0);
        chk("midrst_txdata", 64'(oTXDATA), 64'h00);
        chk("midrst_framedone", 64'(oFRAMEDONE), 64'd0);
        chk("midrst_busy", 64'(oBUSY), 64'd0);
        repeat (2) @(negedge iCLOCK);
        iRESET = 1'b0;
        tx_delay = 5;
        @(negedge iCLOCK) drive(mk(16'hBEEF, 16'hCAFE, 32'h0BADF00D), 1'b1);
        @(negedge iCLOCK) iWRITE = 1'b0;
        wait_frames(fbase + 1, 1000, "post_reset_frame");
        repeat (20) @(negedge iCLOCK);
        chk("post_reset_frames", 64'(frames_done - fbase), 64'd1);
        chk("post_reset_empty", 64'(exp_q.size()), 64'd0);

        // Randomized traffic, writes issued only when acceptance is certain.
        fbase = frames_done;
        acc = 0;
        for (int k = 0; k < 30; k++) begin
            tx_delay = $urandom_range(1, 8);
            repeat ($urandom_range(0, 3)) begin
                @(negedge iCLOCK) iWRITE = 1'b0;
            end
            n = 0;
            while (acc - (frames_done - fbase) >= DEPTH && n < 2000) begin
                @(negedge iCLOCK) iWRITE = 1'b0;
                n++;
            end
            @(negedge iCLOCK);
            chk("rand_ready", 64'(oREADY), 64'd1);
            drive(mk(16'($urandom), 16'($urandom), $urandom), 1'b1);
            acc++;
        end
        @(negedge iCLOCK) iWRITE = 1'b0;
        wait_frames(fbase + 30, 20000, "rand_drain");
        repeat (20) @(negedge iCLOCK);
        chk("rand_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_idle", 64'(oBUSY), 64'd0);
        chk("rand_count", 64'(oCOUNT), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
